// File: rtl/mlp_conv_pkg.sv
// Shared types, default geometry and helpers for the mlp_conv weight loader.
package mlp_conv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} wic_state_e;

  localparam int DEF_INPUT_WIDTH = 32;
  localparam int DEF_ELEM_WIDTH  = 8;
  localparam int DEF_MAX_R       = 5;
  localparam int DEF_MAX_S       = 5;
  localparam int DEF_FIFO_DEPTH  = 16;

  // Counter width for an index range 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] words_per_row(input logic [3:0] s, input int epw);
    return 4'((int'(s) + epw - 1) / epw);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, full/empty flags and a dropped-write pulse.
module sync_fifo
  import mlp_conv_pkg::*;
#(
  parameter int WIDTH = DEF_INPUT_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf
);
  localparam int AW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_ovf     = r_ovf;
  assign o_rd_data = r_mem[r_rd_ptr];
  // A flush wins over any same-cycle push or pop.
  assign w_push    = i_wr && !o_full && !i_clear;
  assign w_pop     = i_rd && !o_empty && !i_clear;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= i_wr && o_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/weight_in_ctrl_db.sv
// Double-buffered weight-store loader: unpacks FIFO words into a shadow bank, then promotes it to active.
// Handshake: a completed shadow bank is promoted when the active bank is free (!WS_VALID) or released by WS_SWAP.
module weight_in_ctrl_db
  import mlp_conv_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int ELEM_WIDTH  = DEF_ELEM_WIDTH,
  parameter int MAX_R       = DEF_MAX_R,
  parameter int MAX_S       = DEF_MAX_S,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              CLEAR,
  input  logic                              FIFO_WR_CMD,
  input  logic [INPUT_WIDTH-1:0]            FIFO_WR_DATA,
  output logic                              FIFO_FULL,
  output logic                              FIFO_EMPTY,
  output logic                              FIFO_OVF,
  input  logic [3:0]                        PARAM_R,
  input  logic [3:0]                        PARAM_S,
  input  logic                              LOAD_WS,
  output logic                              LOAD_BUSY,
  output logic                              LOAD_DONE,
  output logic                              PARAM_ERR,
  input  logic                              WS_SWAP,
  output logic                              WS_VALID,
  output logic                              WS_SHADOW_FULL,
  output logic [MAX_R*MAX_S*ELEM_WIDTH-1:0] WS_RD_DATA,
  output logic [1:0]                        o_dbg_state
);
  localparam int EPW   = INPUT_WIDTH / ELEM_WIDTH;
  localparam int NEL   = MAX_R * MAX_S;
  localparam int DW    = NEL * ELEM_WIDTH;
  localparam int ROW_W = cnt_width(MAX_R);
  localparam int WRD_W = cnt_width(MAX_S);
  localparam logic [3:0] MAX_R4 = 4'(MAX_R);
  localparam logic [3:0] MAX_S4 = 4'(MAX_S);

  wic_state_e       r_state;
  logic [3:0]       r_r, r_s, r_wpr;
  logic [ROW_W-1:0] r_row;
  logic [WRD_W-1:0] r_word;
  logic             r_load_done, r_param_err, r_shadow_full, r_valid, r_sel;
  logic [DW-1:0]    r_bank0, r_bank1;

  logic [INPUT_WIDTH-1:0] w_fifo_rd_data;
  logic             w_fifo_empty, w_pop, w_row_end, w_last, w_legal, w_start;
  logic             w_promote, w_zero_shadow;
  logic [DW-1:0]    w_mask, w_fill;

  sync_fifo #(.WIDTH(INPUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(RESET), .i_clear(CLEAR), .i_wr(FIFO_WR_CMD), .i_wr_data(FIFO_WR_DATA),
    .i_rd(w_pop), .o_rd_data(w_fifo_rd_data), .o_full(FIFO_FULL), .o_empty(w_fifo_empty),
    .o_ovf(FIFO_OVF)
  );

  assign FIFO_EMPTY     = w_fifo_empty;
  assign LOAD_BUSY      = (r_state == LOAD);
  assign LOAD_DONE      = r_load_done;
  assign PARAM_ERR      = r_param_err;
  assign WS_VALID       = r_valid;
  assign WS_SHADOW_FULL = r_shadow_full;
  assign WS_RD_DATA     = r_sel ? r_bank1 : r_bank0;
  assign o_dbg_state    = r_state;

  assign w_legal   = (PARAM_R != 4'd0) && (PARAM_R <= MAX_R4) && (PARAM_S != 4'd0) && (PARAM_S <= MAX_S4);
  assign w_start   = (r_state == IDLE) && LOAD_WS && !r_shadow_full && !CLEAR && w_legal;
  assign w_pop     = (r_state == LOAD) && !w_fifo_empty && !CLEAR;
  assign w_row_end = (r_word == WRD_W'(r_wpr - 4'd1));
  assign w_last    = w_pop && w_row_end && (r_row == ROW_W'(r_r - 4'd1));
  assign w_promote = r_shadow_full && (!r_valid || WS_SWAP) && !CLEAR;
  assign w_zero_shadow = CLEAR || w_start;

  // Per-element write mask for the word being popped; lanes past column S never match.
  always_comb begin
    w_mask = '0;
    w_fill = '0;
    for (int e = 0; e < NEL; e++) begin
      w_fill[e*ELEM_WIDTH +: ELEM_WIDTH] = w_fifo_rd_data[((e % MAX_S) % EPW)*ELEM_WIDTH +: ELEM_WIDTH];
      if ((r_row == ROW_W'(e / MAX_S)) && (r_word == WRD_W'((e % MAX_S) / EPW)) &&
          (4'(e % MAX_S) < r_s))
        w_mask[e*ELEM_WIDTH +: ELEM_WIDTH] = '1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bank0 <= '0;
      r_bank1 <= '0;
    end else if (w_zero_shadow) begin
      if (r_sel) r_bank0 <= '0;
      else       r_bank1 <= '0;
    end else if (w_pop) begin
      if (r_sel) r_bank0 <= (r_bank0 & ~w_mask) | (w_fill & w_mask);
      else       r_bank1 <= (r_bank1 & ~w_mask) | (w_fill & w_mask);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_r           <= '0;
      r_s           <= '0;
      r_wpr         <= '0;
      r_row         <= '0;
      r_word        <= '0;
      r_load_done   <= 1'b0;
      r_param_err   <= 1'b0;
      r_shadow_full <= 1'b0;
      r_valid       <= 1'b0;
      r_sel         <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_param_err <= 1'b0;
      if (CLEAR) begin
        r_state       <= IDLE;
        r_shadow_full <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (LOAD_WS && !r_shadow_full) begin
            if (w_legal) begin
              r_r     <= PARAM_R;
              r_s     <= PARAM_S;
              r_wpr   <= words_per_row(PARAM_S, EPW);
              r_row   <= '0;
              r_word  <= '0;
              r_state <= LOAD;
            end else begin
              r_param_err <= 1'b1;
            end
          end
          LOAD: if (w_pop) begin
            if (w_last) begin
              r_state       <= DONE;
              r_load_done   <= 1'b1;
              r_shadow_full <= 1'b1;
            end else if (w_row_end) begin
              r_word <= '0;
              r_row  <= r_row + 1'b1;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
      // Shadow can only become full from LOAD, so this never collides with the set above.
      if (w_promote) begin
        r_sel         <= ~r_sel;
        r_valid       <= 1'b1;
        r_shadow_full <= 1'b0;
      end else if (WS_SWAP && !r_shadow_full) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_weight_in_ctrl_db.sv
// Scoreboard bench: expected filters queued at load issue, compared whenever the active bank changes.
module tb_weight_in_ctrl_db;
  localparam int EW = 8;
  localparam int EPW = 4;
  localparam int MR = 5;
  localparam int MS = 5;
  localparam int DW = MR * MS * EW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wr_data = '0;
  logic [3:0]    param_r = '0;
  logic [3:0]    param_s = '0;
  logic          load_ws = 1'b0;
  logic          ws_swap = 1'b0;
  logic          fifo_full, fifo_empty, fifo_ovf, load_busy, load_done, param_err;
  logic          ws_valid, ws_shadow_full;
  logic [DW-1:0] ws_rd_data;
  logic [1:0]    dbg_state;

  logic [DW-1:0] exp_q[$];
  logic [31:0]   pat_q[$];
  logic [31:0]   big_q[$];
  logic [DW-1:0] last_rd = '0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            fifo_cnt = 0;
  bit            model_valid = 0;

  weight_in_ctrl_db dut (
    .CLK(clk), .RESET(rst), .CLEAR(clear), .FIFO_WR_CMD(wr), .FIFO_WR_DATA(wr_data),
    .FIFO_FULL(fifo_full), .FIFO_EMPTY(fifo_empty), .FIFO_OVF(fifo_ovf),
    .PARAM_R(param_r), .PARAM_S(param_s), .LOAD_WS(load_ws), .LOAD_BUSY(load_busy),
    .LOAD_DONE(load_done), .PARAM_ERR(param_err), .WS_SWAP(ws_swap), .WS_VALID(ws_valid),
    .WS_SHADOW_FULL(ws_shadow_full), .WS_RD_DATA(ws_rd_data), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Filter contents derived directly from the row/column/lane rules.
  function automatic logic [DW-1:0] model_filter(input int r, input int s);
    logic [DW-1:0] f;
    logic [31:0]   w;
    int            wpr;
    f = '0;
    wpr = (s + EPW - 1) / EPW;
    for (int rr = 0; rr < r; rr++)
      for (int c = 0; c < s; c++) begin
        w = pat_q[rr*wpr + c/EPW];
        f[(rr*MS + c)*EW +: EW] = w[(c % EPW)*EW +: EW];
      end
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_rd = ws_rd_data;
    end else if (ws_rd_data !== last_rd) begin
      if (exp_q.size() == 0) check("rd_data_unexpected_change", ws_rd_data, last_rd);
      else check("rd_data_filter", ws_rd_data, exp_q.pop_front());
      last_rd = ws_rd_data;
    end
  end

  task automatic write_word(input logic [31:0] d);
    wr = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr = 1'b0;
    if (fifo_cnt < 16) fifo_cnt++;
    check("fifo_full_flag", fifo_full, (fifo_cnt == 16));
    check("fifo_empty_flag", fifo_empty, 1'b0);
  endtask

  task automatic start_load(input int r, input int s);
    param_r = 4'(r);
    param_s = 4'(s);
    load_ws = 1'b1;
    @(negedge clk);
    load_ws = 1'b0;
  endtask

  task automatic pulse_swap();
    ws_swap = 1'b1;
    @(negedge clk);
    ws_swap = 1'b0;
  endtask

  task automatic fill_random(input int n);
    pat_q.delete();
    for (int i = 0; i < n; i++) pat_q.push_back($urandom());
  endtask

  task automatic do_load(input int r, input int s, input bit write_pat, input bit do_swap);
    int wpr;
    int lat;
    wpr = (s + EPW - 1) / EPW;
    exp_q.push_back(model_filter(r, s));
    if (write_pat) foreach (pat_q[i]) write_word(pat_q[i]);
    start_load(r, s);
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (load_done) begin
        lat = k;
        break;
      end
    end
    fifo_cnt -= r * wpr;
    check("load_latency", lat, r * wpr);
    check("valid_at_done", ws_valid, model_valid);
    check("fifo_empty_after_load", fifo_empty, (fifo_cnt == 0));
    @(negedge clk);
    check("load_done_one_cycle", load_done, 1'b0);
    if (model_valid) begin
      check("shadow_full_waiting", ws_shadow_full, 1'b1);
      if (do_swap) pulse_swap();
    end
    if (!model_valid || do_swap) begin
      check("valid_after_promote", ws_valid, 1'b1);
      check("shadow_empty_after_promote", ws_shadow_full, 1'b0);
    end
    model_valid = 1;
  endtask

  initial begin
    int tbl_r[4];
    int tbl_s[4];
    int done_seen;
    tbl_r = '{0, 3, 6, 3};
    tbl_s = '{3, 6, 2, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_fifo_empty", fifo_empty, 1'b1);
    check("rst_fifo_ovf", fifo_ovf, 1'b0);
    check("rst_load_busy", load_busy, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_param_err", param_err, 1'b0);
    check("rst_ws_valid", ws_valid, 1'b0);
    check("rst_shadow_full", ws_shadow_full, 1'b0);
    check("rst_rd_data", ws_rd_data, '0);
    check("rst_state_idle", dbg_state, 2'd0);

    // R=3, S=3: one word per row, lane 3 dropped.
    pat_q = '{32'hDDCCBBAA, 32'h44332211, 32'h0F0E0D0C};
    do_load(3, 3, 1, 1);
    check("t1_r0c0", ws_rd_data[7:0], 8'hAA);
    check("t1_r0c2", ws_rd_data[23:16], 8'hCC);
    check("t1_r0c3_zero", ws_rd_data[31:24], 8'h00);
    check("t1_r2c2", ws_rd_data[103:96], 8'h0E);
    check("t1_r3_zero", ws_rd_data[127:120], 8'h00);

    // R=2, S=5: two words per row, upper lanes of the second word dropped.
    pat_q = '{32'h03020100, 32'h07060504, 32'h13121110, 32'h17161514};
    do_load(2, 5, 1, 1);
    check("t2_r0c4", ws_rd_data[39:32], 8'h04);
    check("t2_r1c0", ws_rd_data[47:40], 8'h10);
    check("t2_r1c4", ws_rd_data[79:72], 8'h14);
    check("t2_r2_zero", ws_rd_data[87:80], 8'h00);

    foreach (tbl_r[i]) begin
      start_load(tbl_r[i], tbl_s[i]);
      check("param_err_pulse", param_err, 1'b1);
      check("param_err_not_busy", load_busy, 1'b0);
      @(negedge clk);
      check("param_err_clears", param_err, 1'b0);
      check("param_err_still_idle", load_busy, 1'b0);
    end

    // Release the active bank, then a swap with nothing valid must do nothing.
    pulse_swap();
    check("release_valid_low", ws_valid, 1'b0);
    pulse_swap();
    check("swap_idle_no_effect", ws_valid, 1'b0);
    model_valid = 0;

    // Double buffer: A auto-promotes, B waits in shadow, a third request is dropped.
    fill_random(2);
    do_load(2, 4, 1, 1);
    fill_random(6);
    do_load(3, 6 - 1, 1, 0);
    start_load(2, 2);
    check("third_load_ignored", load_busy, 1'b0);
    check("third_load_shadow_full", ws_shadow_full, 1'b1);
    pulse_swap();
    check("swap_valid", ws_valid, 1'b1);
    check("swap_shadow_empty", ws_shadow_full, 1'b0);
    @(negedge clk);
    check("third_load_not_held", load_busy, 1'b0);

    for (int it = 0; it < 10; it++) begin
      int r;
      int s;
      r = $urandom_range(1, 5);
      s = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) begin
        pulse_swap();
        check("rand_release", ws_valid, 1'b0);
        model_valid = 0;
      end
      fill_random(r * ((s + EPW - 1) / EPW));
      do_load(r, s, 1, 1);
    end

    // CLEAR in the cycle that would carry the last pop.
    fill_random(3);
    foreach (pat_q[i]) write_word(pat_q[i]);
    start_load(3, 4);
    repeat (2) @(negedge clk);
    check("clear_busy_before", load_busy, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    fifo_cnt = 0;
    done_seen = 0;
    check("clear_state_idle", dbg_state, 2'd0);
    check("clear_fifo_empty", fifo_empty, 1'b1);
    check("clear_valid_kept", ws_valid, 1'b1);
    check("clear_shadow_empty", ws_shadow_full, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (load_done) done_seen++;
      @(negedge clk);
    end
    check("clear_no_load_done", done_seen, 0);
    fill_random(1);
    do_load(1, 1, 1, 1);

    // FIFO boundaries: 16 accepted, 17th dropped, four R=4,S=4 loads drain it.
    fill_random(17);
    big_q = pat_q;
    for (int i = 0; i < 16; i++) write_word(big_q[i]);
    check("fifo_full_at_16", fifo_full, 1'b1);
    check("no_ovf_at_16", fifo_ovf, 1'b0);
    wr = 1'b1;
    wr_data = big_q[16];
    @(negedge clk);
    wr = 1'b0;
    check("ovf_pulse", fifo_ovf, 1'b1);
    @(negedge clk);
    check("ovf_one_cycle", fifo_ovf, 1'b0);
    for (int ld = 0; ld < 4; ld++) begin
      pat_q.delete();
      for (int j = 0; j < 4; j++) pat_q.push_back(big_q[4*ld + j]);
      do_load(4, 4, 0, 1);
    end
    check("fifo_drained", fifo_empty, 1'b1);

    // Asynchronous reset in the middle of a load.
    fill_random(3);
    foreach (pat_q[i]) write_word(pat_q[i]);
    start_load(3, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", load_busy, 1'b0);
    check("arst_valid", ws_valid, 1'b0);
    check("arst_rd_data", ws_rd_data, '0);
    check("arst_fifo_empty", fifo_empty, 1'b1);
    check("arst_state", dbg_state, 2'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    fifo_cnt = 0;
    model_valid = 0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", load_busy, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
